// File: rtl/cal_pkg.sv
// Shared calendar constants: field widths, legal year range, month-length
// table and the Gregorian leap-year rule.
package cal_pkg;

  localparam int YEAR_W  = 16;
  localparam int MONTH_W = 8;
  localparam int DAY_W   = 8;

  localparam logic [YEAR_W-1:0]  MIN_YEAR        = 16'd1;
  localparam logic [YEAR_W-1:0]  MAX_YEAR        = 16'd9999;
  localparam logic [MONTH_W-1:0] MONTHS_PER_YEAR = 8'd12;

  // Index 0 is January; February holds its common-year length.
  localparam logic [DAY_W-1:0] MONTH_LEN [12] = '{
    8'd31, 8'd28, 8'd31, 8'd30, 8'd31, 8'd30,
    8'd31, 8'd31, 8'd30, 8'd31, 8'd30, 8'd31
  };
  localparam logic [DAY_W-1:0] FEB_LEAP_LEN = 8'd29;

  // Gregorian rule, evaluated entirely in 16-bit unsigned arithmetic.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return ((y % 16'd4) == 16'd0) &&
           (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Combinational month-length lookup. An out-of-range month reports zero
// days, so any day compared against it is automatically rejected.
module cal_month_len
  import cal_pkg::*;
(
  input  logic [YEAR_W-1:0]  i_year,
  input  logic [MONTH_W-1:0] i_month,
  output logic               o_leap,
  output logic [DAY_W-1:0]   o_days
);

  logic [3:0] w_idx;

  assign o_leap = is_leap(i_year);

  // Table lookup with the February leap-day correction.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an untaken branch infers a latch.
    o_days = '0;
    w_idx  = i_month[3:0] - 4'd1;
    if ((i_month >= 8'd1) && (i_month <= MONTHS_PER_YEAR)) begin
      if ((i_month == 8'd2) && o_leap) begin
        o_days = FEB_LEAP_LEN;
      end else begin
        o_days = MONTH_LEN[w_idx];
      end
    end
  end

endmodule

// File: rtl/cal_date_counter.sv
// Calendar date register: advances one day per day_tick, accepts validated
// date loads (load beats a simultaneous tick), and wraps 9999-12-31 to
// 0001-01-01. The reset parameters are expected to form a legal date.
module cal_date_counter
  import cal_pkg::*;
#(
  parameter logic [YEAR_W-1:0]  RESET_YEAR  = 16'd2000,
  parameter logic [MONTH_W-1:0] RESET_MONTH = 8'd1,
  parameter logic [DAY_W-1:0]   RESET_DAY   = 8'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               day_tick,
  input  logic               load,
  input  logic [YEAR_W-1:0]  set_year,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [DAY_W-1:0]   set_day,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic               leap,
  output logic               date_upd,
  output logic               load_err
);

  logic [YEAR_W-1:0]  r_year;
  logic [MONTH_W-1:0] r_month;
  logic [DAY_W-1:0]   r_day;
  logic               r_leap;
  logic               r_date_upd;
  logic               r_load_err;

  logic               w_cur_leap;
  logic [DAY_W-1:0]   w_cur_days;
  logic               w_set_leap;
  logic [DAY_W-1:0]   w_set_days;
  logic               w_set_valid;
  logic [YEAR_W-1:0]  w_year_inc;

  logic [YEAR_W-1:0]  w_year_nxt;
  logic [MONTH_W-1:0] w_month_nxt;
  logic [DAY_W-1:0]   w_day_nxt;
  logic               w_leap_nxt;
  logic               w_upd_nxt;
  logic               w_err_nxt;

  // Length of the month currently held.
  cal_month_len u_cur_len (
    .i_year  (r_year),
    .i_month (r_month),
    .o_leap  (w_cur_leap),
    .o_days  (w_cur_days)
  );

  // Length of the month being loaded, for validating set_day.
  cal_month_len u_set_len (
    .i_year  (set_year),
    .i_month (set_month),
    .o_leap  (w_set_leap),
    .o_days  (w_set_days)
  );

  // A zero w_set_days (bad month) makes the day check fail on its own.
  assign w_set_valid = (set_year >= MIN_YEAR) && (set_year <= MAX_YEAR) &&
                       (set_day != 8'd0) && (set_day <= w_set_days);

  assign w_year_inc = (r_year >= MAX_YEAR) ? MIN_YEAR : (r_year + 16'd1);

  // Next-date selection: load has priority, then tick, else hold.
  always_comb begin
    w_year_nxt  = r_year;
    w_month_nxt = r_month;
    w_day_nxt   = r_day;
    w_leap_nxt  = w_cur_leap;
    w_upd_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      if (w_set_valid) begin
        w_year_nxt  = set_year;
        w_month_nxt = set_month;
        w_day_nxt   = set_day;
        w_leap_nxt  = w_set_leap;
        w_upd_nxt   = 1'b1;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (day_tick) begin
      w_upd_nxt = 1'b1;
      if (r_day < w_cur_days) begin
        w_day_nxt = r_day + 8'd1;
      end else if (r_month < MONTHS_PER_YEAR) begin
        w_day_nxt   = 8'd1;
        w_month_nxt = r_month + 8'd1;
      end else begin
        w_day_nxt   = 8'd1;
        w_month_nxt = 8'd1;
        w_year_nxt  = w_year_inc;
        w_leap_nxt  = is_leap(w_year_inc);
      end
    end
  end

  // Date and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year     <= RESET_YEAR;
      r_month    <= RESET_MONTH;
      r_day      <= RESET_DAY;
      r_leap     <= is_leap(RESET_YEAR);
      r_date_upd <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      r_year     <= w_year_nxt;
      r_month    <= w_month_nxt;
      r_day      <= w_day_nxt;
      r_leap     <= w_leap_nxt;
      r_date_upd <= w_upd_nxt;
      r_load_err <= w_err_nxt;
    end
  end

  assign year     = r_year;
  assign month    = r_month;
  assign day      = r_day;
  assign leap     = r_leap;
  assign date_upd = r_date_upd;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_cal_date_counter.sv
// Self-checking bench for cal_date_counter: directed calendar corner cases
// followed by randomized ticks/loads against a plain-arithmetic date model.
module tb_cal_date_counter;

  logic        clk;
  logic        rst_n;
  logic        day_tick;
  logic        load;
  logic [15:0] set_year;
  logic [7:0]  set_month;
  logic [7:0]  set_day;
  logic [15:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic        leap;
  logic        date_upd;
  logic        load_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_y, m_m, m_d;
  int e_upd, e_err;

  cal_date_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .day_tick  (day_tick),
    .load      (load),
    .set_year  (set_year),
    .set_month (set_month),
    .set_day   (set_day),
    .year      (year),
    .month     (month),
    .day       (day),
    .leap      (leap),
    .date_upd  (date_upd),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_leap(input int y);
    return ((y % 400) == 0) || (((y % 4) == 0) && ((y % 100) != 0));
  endfunction

  function automatic int m_dim(input int y, input int m);
    int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && m_leap(y) != 0) return 29;
    return len[m-1];
  endfunction

  function automatic int m_legal(input int y, input int m, input int d);
    return (y >= 1) && (y <= 9999) && (m >= 1) && (m <= 12) &&
           (d >= 1) && (d <= m_dim(y, m));
  endfunction

  task automatic model_reset();
    m_y = 2000; m_m = 1; m_d = 1; e_upd = 0; e_err = 0;
  endtask

  task automatic model_step(input bit t, input bit l, input int y, input int mo, input int d);
    e_upd = 0; e_err = 0;
    if (l) begin
      if (m_legal(y, mo, d) != 0) begin
        m_y = y; m_m = mo; m_d = d; e_upd = 1;
      end else begin
        e_err = 1;
      end
    end else if (t) begin
      e_upd = 1;
      m_d++;
      if (m_d > m_dim(m_y, m_m)) begin
        m_d = 1;
        m_m++;
        if (m_m > 12) begin
          m_m = 1;
          m_y = (m_y == 9999) ? 1 : m_y + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".year"},     year,     m_y);
    check({tag, ".month"},    month,    m_m);
    check({tag, ".day"},      day,      m_d);
    check({tag, ".leap"},     leap,     m_leap(m_y));
    check({tag, ".date_upd"}, date_upd, e_upd);
    check({tag, ".load_err"}, load_err, e_err);
  endtask

  // One clock cycle: drive on the falling edge, check 1 ns after the rise.
  task automatic cycle(input string tag, input bit t, input bit l,
                       input int y, input int mo, input int d);
    @(negedge clk);
    day_tick  = t;
    load      = l;
    set_year  = y[15:0];
    set_month = mo[7:0];
    set_day   = d[7:0];
    model_step(t, l, y, mo, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    day_tick = 1'b0; load = 1'b0;
    set_year = '0; set_month = '0; set_day = '0;
  endtask

  int upd_count;
  int ry, rm, rd, kind;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 31 ticks through January 2000.
    upd_count = 0;
    for (int i = 0; i < 31; i++) begin
      cycle("jan2000", 1'b1, 1'b0, 0, 0, 0);
      upd_count += int'(date_upd);
    end
    check("jan2000.upd_pulses", upd_count, 31);
    cycle("jan2000.idle", 1'b0, 1'b0, 0, 0, 0);

    // Leap February and a century non-leap.
    cycle("ld2024", 1'b0, 1'b1, 2024, 2, 28);
    cycle("t2024a", 1'b1, 1'b0, 0, 0, 0);
    cycle("t2024b", 1'b1, 1'b0, 0, 0, 0);
    cycle("ld1900", 1'b0, 1'b1, 1900, 2, 28);
    cycle("t1900",  1'b1, 1'b0, 0, 0, 0);

    // Year rollover including the 9999 wrap.
    cycle("ld9999", 1'b0, 1'b1, 9999, 12, 31);
    cycle("wrap",   1'b1, 1'b0, 0, 0, 0);
    cycle("ld2023", 1'b0, 1'b1, 2023, 12, 31);
    cycle("ny2024", 1'b1, 1'b0, 0, 0, 0);

    // Illegal loads leave the date alone.
    cycle("bad_feb29", 1'b0, 1'b1, 2023, 2, 29);
    cycle("bad_month", 1'b0, 1'b1, 2023, 13, 1);
    cycle("bad_year0", 1'b0, 1'b1, 0, 1, 1);
    cycle("bad_idle",  1'b0, 1'b0, 0, 0, 0);

    // Load beats a simultaneous tick.
    cycle("ld_and_tick", 1'b1, 1'b1, 2020, 6, 15);
    cycle("after_ld",    1'b0, 1'b0, 0, 0, 0);

    // Asynchronous reset in the middle of a tick burst.
    for (int i = 0; i < 4; i++) cycle("burst", 1'b1, 1'b0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    cycle("first_tick", 1'b1, 1'b0, 0, 0, 0);

    // Randomized mix of ticks, idles, legal/boundary/illegal loads.
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        cycle("rnd_tick", 1'b1, 1'b0, 0, 0, 0);
      end else if (kind == 5) begin
        cycle("rnd_idle", 1'b0, 1'b0, 0, 0, 0);
      end else if (kind <= 7) begin
        ry = $urandom_range(1, 9999);
        rm = $urandom_range(1, 12);
        rd = $urandom_range(1, m_dim(ry, rm));
        cycle("rnd_load", $urandom_range(0, 1) == 1, 1'b1, ry, rm, rd);
      end else if (kind == 8) begin
        case ($urandom_range(0, 2))
          0:       ry = 0;
          1:       ry = $urandom_range(1, 9999);
          default: ry = $urandom_range(10000, 65535);
        endcase
        rm = $urandom_range(0, 15);
        rd = $urandom_range(0, 33);
        cycle("rnd_any", 1'b0, 1'b1, ry, rm, rd);
      end else begin
        case ($urandom_range(0, 4))
          0:       ry = 9999;
          1:       ry = 1900;
          2:       ry = 2000;
          3:       ry = 2099;
          default: ry = 2100;
        endcase
        rm = ($urandom_range(0, 1) == 1) ? 12 : 2;
        rd = m_dim(ry, rm) - $urandom_range(0, 1);
        cycle("rnd_edge", 1'b0, 1'b1, ry, rm, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cal_date_counter.md
CAL_DATE_COUNTER -- requirements
Module: cal_date_counter

Interface
REQ-001 SHALL have parameter RESET_YEAR, default 16'd2000, meaning year loaded at reset.
REQ-002 SHALL have parameter RESET_MONTH, default 8'd1, meaning month loaded at reset.
REQ-003 SHALL have parameter RESET_DAY, default 8'd1, meaning day loaded at reset.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port day_tick  input  1  one-cycle pulse; advance date by one day.
REQ-007 SHALL have port load  input  1  one-cycle pulse; load set_year/set_month/set_day.
REQ-008 SHALL have port set_year  input  16  year to load, legal range 1..9999.
REQ-009 SHALL have port set_month  input  8  month to load, legal range 1..12.
REQ-010 SHALL have port set_day  input  8  day to load, legal range 1..days-in-month(set_year, set_month).
REQ-011 SHALL have port year  output  16  current year, registered.
REQ-012 SHALL have port month  output  8  current month 1..12, registered.
REQ-013 SHALL have port day  output  8  current day 1..31, registered.
REQ-014 SHALL have port leap  output  1  current year is a leap year, registered.
REQ-015 SHALL have port date_upd  output  1  one-cycle strobe: year/month/day changed this cycle.
REQ-016 SHALL have port load_err  output  1  one-cycle strobe: last load rejected as an illegal date.

Function
REQ-017 SHALL treat a year as leap iff divisible by 4 and (not divisible by 100 or divisible by 400).
REQ-018 SHALL use month lengths 31,28/29,31,30,31,30,31,31,30,31,30,31; February is 29 when leap.
REQ-019 On day_tick with day < month length: day+1; month and year unchanged.
REQ-020 On day_tick with day == month length and month < 12: day=1, month+1.
REQ-021 On day_tick at 12/31: day=1, month=1, year+1; at 9999-12-31 SHALL wrap to 0001-01-01.
REQ-022 On load with a legal date: registers take set_* values on the same edge; date_upd=1 next cycle.
REQ-023 On load with an illegal date (year 0 or >9999, month 0 or >12, day 0 or > month length): registers unchanged, load_err=1 for one cycle, date_upd=0.
REQ-024 load and day_tick asserted together: load SHALL win and the tick SHALL be discarded.
REQ-025 Latency: outputs and leap SHALL reflect the new date one clock after the triggering edge; date_upd asserts in that same cycle.
REQ-026 leap SHALL always be consistent with year (recomputed whenever year changes, including on load and wrap).
REQ-027 Back-to-back day_tick on consecutive cycles SHALL advance one day per cycle with no lost ticks.
REQ-028 Outputs SHALL feed the downstream day-of-week stage directly; date_upd marks when its result becomes valid.

Reset
REQ-029 rst_n low SHALL set year=RESET_YEAR, month=RESET_MONTH, day=RESET_DAY, leap=leap(RESET_YEAR), date_upd=0, load_err=0, independent of clk.
REQ-030 Reset mid-operation SHALL discard any pending tick or load; the first tick after rst_n rises SHALL be honoured.
REQ-031 The reset parameters SHALL form a legal date; an illegal combination is a configuration error.

Structure
REQ-032 A shared package cal_pkg SHALL hold the year/month/day width constants, the min/max year (1, 9999), and the month-length table.
REQ-033 A combinational sub-module cal_month_len (inputs year, month; outputs leap, days-in-month) SHALL be instantiated twice: current date and load-validation path.
REQ-034 No other sub-modules; arithmetic SHALL be evaluated in 16-bit unsigned without negative intermediates.

Verification
REQ-035 Reset, then 31 ticks from 2000-01-01 -> 2000-02-01, leap=1, date_upd pulses 31 times.
REQ-036 Load 2024-02-28, two ticks -> 2024-02-29 then 2024-03-01; load 1900-02-28, one tick -> 1900-03-01, leap=0.
REQ-037 Load 9999-12-31, one tick -> 0001-01-01, leap=0; load 2023-12-31, one tick -> 2024-01-01, leap=1.
REQ-038 Load 2023-02-29 -> load_err pulse, date unchanged, date_upd=0; load 2023-13-01 and 0000-01-01 -> same.
REQ-039 load 2020-06-15 with day_tick in the same cycle -> 2020-06-15 (tick discarded).
REQ-040 Assert rst_n low between clock edges during a tick burst -> outputs go to 2000-01-01 immediately, strobes 0.
